systolic_frame_tx: RTL and testbench

Host-side framing transmitter for the systolic tile link. It accepts whole 16-bit row and column words with 4-bit control tags over valid/ready handshakes. Each word is serialized MSB-nibble-first into the tile's 4-cycle nibble frame, with one control bit per nibble. It sits between the host/test logic and a tile's row/col nibble inputs, and its frame phase is lock-stepped to the tile's block counter through a shared reset.

---
 rtl/systolic_frame_tx_pkg.sv | 13 +
 rtl/systolic_frame_tx_if.sv | 24 ++
 rtl/systolic_frame_tx_lane_ser.sv | 82 ++++++++
 rtl/systolic_frame_tx.sv | 68 ++++++
 tb/tb_systolic_frame_tx.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_frame_tx_pkg.sv
// Shared constants for the systolic tile link: nibble/frame geometry and phase type.
// The tile-side receiver imports the same package so both ends agree on framing.
package systolic_pkg;

    localparam int NIBBLE_W  = 4;
    localparam int FRAME_LEN = 4;
    localparam int WORD_W    = NIBBLE_W * FRAME_LEN;

    typedef logic [1:0] phase_t;

    localparam phase_t LOAD_PHASE = phase_t'(FRAME_LEN - 1);

endpackage

// File: rtl/systolic_frame_tx_if.sv
// Word-level valid/ready lane carrying one 16-bit word and its 4-bit control tag.
// The host drives the master side; the framing transmitter is the slave.
interface systolic_frame_tx_if import systolic_pkg::*;;

    logic [WORD_W-1:0]    data;
    logic [FRAME_LEN-1:0] ctrl;
    logic                 valid;
    logic                 ready;

    modport master (
        output data,
        output ctrl,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  ctrl,
        input  valid,
        output ready
    );

endinterface

// File: rtl/systolic_frame_tx_lane_ser.sv
// One transmit lane: one-entry holding buffer, load-edge bypass, and the nibble/ctrl
// shift registers whose MSBs drive the tile directly from flops.
module systolic_lane_ser
    import systolic_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 shift,
    systolic_frame_tx_if.slave   word_if,
    output logic [NIBBLE_W-1:0]  nib_out,
    output logic                 ctrl_out
);

    logic [WORD_W-1:0]    buf_data_q, buf_data_d;
    logic [FRAME_LEN-1:0] buf_ctrl_q, buf_ctrl_d;
    logic                 full_q,     full_d;
    logic [WORD_W-1:0]    sh_data_q,  sh_data_d;
    logic [FRAME_LEN-1:0] sh_ctrl_q,  sh_ctrl_d;
    logic                 accept;

    // At a load edge the buffer drains into the shift register, so it can take a word
    // even while full.
    assign word_if.ready = !full_q || load;
    assign accept        = word_if.valid && word_if.ready;

    always_comb begin
        buf_data_d = buf_data_q;
        buf_ctrl_d = buf_ctrl_q;
        full_d     = full_q;
        sh_data_d  = sh_data_q;
        sh_ctrl_d  = sh_ctrl_q;

        if (load) begin
            if (full_q) begin
                sh_data_d = buf_data_q;
                sh_ctrl_d = buf_ctrl_q;
                full_d    = accept;
                if (accept) begin
                    buf_data_d = word_if.data;
                    buf_ctrl_d = word_if.ctrl;
                end
            end else if (accept) begin
                sh_data_d = word_if.data;
                sh_ctrl_d = word_if.ctrl;
            end else begin
                sh_data_d = '0;
                sh_ctrl_d = '0;
            end
        end else begin
            if (shift) begin
                sh_data_d = {sh_data_q[WORD_W-NIBBLE_W-1:0], {NIBBLE_W{1'b0}}};
                sh_ctrl_d = {sh_ctrl_q[FRAME_LEN-2:0], 1'b0};
            end
            if (accept) begin
                buf_data_d = word_if.data;
                buf_ctrl_d = word_if.ctrl;
                full_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_data_q <= '0;
            buf_ctrl_q <= '0;
            full_q     <= 1'b0;
            sh_data_q  <= '0;
            sh_ctrl_q  <= '0;
        end else begin
            buf_data_q <= buf_data_d;
            buf_ctrl_q <= buf_ctrl_d;
            full_q     <= full_d;
            sh_data_q  <= sh_data_d;
            sh_ctrl_q  <= sh_ctrl_d;
        end
    end

    assign nib_out  = sh_data_q[WORD_W-1 -: NIBBLE_W];
    assign ctrl_out = sh_ctrl_q[FRAME_LEN-1];

endmodule

// File: rtl/systolic_frame_tx.sv
// Host-side framing transmitter: owns the frame phase counter (lock-stepped to the
// tile's block counter via the shared reset) and drives two independent lanes.
module systolic_frame_tx
    import systolic_pkg::phase_t;
#(
    parameter int NIBBLE_W  = 4,
    parameter int FRAME_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    systolic_frame_tx_if.slave   row_if,
    systolic_frame_tx_if.slave   col_if,
    output logic [NIBBLE_W-1:0]  row_out,
    output logic                 row_ctrl_out,
    output logic [NIBBLE_W-1:0]  col_out,
    output logic                 col_ctrl_out,
    output phase_t               frame_phase
);

    localparam phase_t LAST_PHASE = phase_t'(FRAME_LEN - 1);

    phase_t phase_q, phase_d;
    logic   load;
    logic   shift;

    assign load  = (phase_q == LAST_PHASE);
    assign shift = !load;

    always_comb begin
        phase_d = phase_q;
        if (load) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign frame_phase = phase_q;

    systolic_lane_ser u_row_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .shift    (shift),
        .word_if  (row_if),
        .nib_out  (row_out),
        .ctrl_out (row_ctrl_out)
    );

    systolic_lane_ser u_col_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .shift    (shift),
        .word_if  (col_if),
        .nib_out  (col_out),
        .ctrl_out (col_ctrl_out)
    );

endmodule

// File: tb/tb_systolic_frame_tx.sv
// Scoreboard bench for systolic_frame_tx: a frame-level reference model predicts each
// cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_systolic_frame_tx;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row_out, col_out;
    logic       row_ctrl_out, col_ctrl_out;
    logic [1:0] frame_phase;

    systolic_frame_tx_if row_if ();
    systolic_frame_tx_if col_if ();

    systolic_frame_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .row_if       (row_if),
        .col_if       (col_if),
        .row_out      (row_out),
        .row_ctrl_out (row_ctrl_out),
        .col_out      (col_out),
        .col_ctrl_out (col_ctrl_out),
        .frame_phase  (frame_phase)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] ph;
        logic [3:0] ro;
        logic       rc;
        logic [3:0] co;
        logic       cc;
        logic       rr;
        logic       cr;
    } exp_t;

    int n_total = 0;
    int n_bad   = 0;

    exp_t        exp_q[$];
    int          m_phase = 0;
    logic [19:0] cur[2];
    logic [19:0] pq[2][$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
        end
    endtask

    // Expected output of the current beat: nibble/bit 'phase' of the current frame word.
    function automatic exp_t make_exp();
        exp_t e;
        e.ph = 2'(m_phase);
        e.ro = cur[0][15 - 4*m_phase -: 4];
        e.rc = cur[0][19 - m_phase];
        e.co = cur[1][15 - 4*m_phase -: 4];
        e.cc = cur[1][19 - m_phase];
        e.rr = (pq[0].size() == 0) || (m_phase == 3);
        e.cr = (pq[1].size() == 0) || (m_phase == 3);
        return e;
    endfunction

    initial begin
        cur[0] = '0;
        cur[1] = '0;
    end

    // Reference model: words wait in a per-lane FIFO; each load edge starts a new frame
    // from the oldest waiting word, else the word offered at that edge, else idle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            for (int l = 0; l < 2; l++) begin
                pq[l].delete();
                cur[l] = '0;
            end
            exp_q.delete();
        end else begin
            logic        in_v[2];
            logic [19:0] in_w[2];
            logic        ld, rdy, acc;
            in_v[0] = row_if.valid;
            in_w[0] = {row_if.ctrl, row_if.data};
            in_v[1] = col_if.valid;
            in_w[1] = {col_if.ctrl, col_if.data};
            ld = (m_phase == 3);
            for (int l = 0; l < 2; l++) begin
                rdy = (pq[l].size() == 0) || ld;
                acc = in_v[l] && rdy;
                if (ld) begin
                    if (pq[l].size() != 0) begin
                        cur[l] = pq[l].pop_front();
                        if (acc) pq[l].push_back(in_w[l]);
                    end else if (acc) begin
                        cur[l] = in_w[l];
                    end else begin
                        cur[l] = '0;
                    end
                end else if (acc) begin
                    pq[l].push_back(in_w[l]);
                end
            end
            m_phase = (m_phase + 1) % 4;
            exp_q.push_back(make_exp());
        end
    end

    always @(posedge rst_n) exp_q.push_back(make_exp());

    always @(negedge clk) begin
        exp_t got, e;
        got.ph = frame_phase;
        got.ro = row_out;
        got.rc = row_ctrl_out;
        got.co = col_out;
        got.cc = col_ctrl_out;
        got.rr = row_if.ready;
        got.cr = col_if.ready;
        if (!rst_n) begin
            e = '0;
            e.rr = 1'b1;
            e.cr = 1'b1;
            chk("reset_state", 32'(got), 32'(e));
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("beat", 32'(got), 32'(e));
        end else begin
            chk("no_expectation", 32'(got), 32'hFFFF_FFFF);
        end
    end

    task automatic set_row(input logic v, input logic [15:0] d, input logic [3:0] c);
        row_if.valid = v;
        row_if.data  = d;
        row_if.ctrl  = c;
    endtask

    task automatic set_col(input logic v, input logic [15:0] d, input logic [3:0] c);
        col_if.valid = v;
        col_if.data  = d;
        col_if.ctrl  = c;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input logic [1:0] p);
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (frame_phase == p) return;
        end
        chk("wait_phase_timeout", 32'(frame_phase), 32'(p));
    endtask

    initial begin
        logic [15:0] words[3];
        int          i;
        logic        r;
        set_row(1'b0, 16'h0, 4'h0);
        set_col(1'b0, 16'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle: 8 cycles with nothing offered.
        repeat (8) cycle();

        // Bypass: offer during the phase-3 cycle only.
        wait_phase(2'd3);
        set_row(1'b1, 16'hA5C3, 4'b1001);
        cycle();
        set_row(1'b0, 16'h0, 4'h0);
        repeat (8) cycle();

        // Buffered column word with an idle row lane.
        wait_phase(2'd1);
        set_col(1'b1, 16'h1234, 4'b0100);
        cycle();
        set_col(1'b0, 16'h0, 4'h0);
        repeat (8) cycle();

        // Back-to-back row words; advance only when the word was accepted.
        words[0] = 16'h1111;
        words[1] = 16'h2222;
        words[2] = 16'h3333;
        i = 0;
        for (int k = 0; k < 40 && i < 3; k++) begin
            set_row(1'b1, words[i], 4'b1000);
            r = row_if.ready;
            cycle();
            if (r) i++;
        end
        chk("b2b_all_accepted", 32'(i), 32'd3);
        set_row(1'b0, 16'h0, 4'h0);
        repeat (12) cycle();

        // Mid-frame reset with a second word sitting in the buffer.
        wait_phase(2'd3);
        set_row(1'b1, 16'hBEEF, 4'b1111);
        cycle();
        set_row(1'b1, 16'h7777, 4'b0110);
        cycle();
        set_row(1'b0, 16'h0, 4'h0);
        wait_phase(2'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_row", 32'({row_out, row_ctrl_out}), 32'd0);
        chk("async_rst_col", 32'({col_out, col_ctrl_out}), 32'd0);
        chk("async_rst_phase", 32'(frame_phase), 32'd0);
        chk("async_rst_ready", 32'({row_if.ready, col_if.ready}), 32'b11);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) cycle();

        // Randomized traffic on both lanes.
        for (int k = 0; k < 600; k++) begin
            set_row(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom));
            set_col(1'($urandom_range(0, 2) != 0), 16'($urandom), 4'($urandom));
            cycle();
        end
        set_row(1'b0, 16'h0, 4'h0);
        set_col(1'b0, 16'h0, 4'h0);
        repeat (8) cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
